phys_free_list: RTL and testbench

Physical-register free list that sits between rename and the reorder buffer. It hands a free physical tag to rename on every allocation and reclaims the stale mapping (`preg_old`) the ROB emits on each retirement. It also snapshots its head pointer per ROB tag at branch dispatch, so a mispredict returns every register allocated after the branch in one cycle.

---
 rtl/phys_free_list_pkg.sv | 19 +
 rtl/phys_free_list_ckpt.sv | 31 +++
 rtl/phys_free_list.sv | 119 +++++++++++
 tb/tb_phys_free_list.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/phys_free_list_pkg.sv
// Shared sizes and types for the physical-register free list and its
// branch checkpoint storage.
package phys_free_list_pkg;

  localparam int NUM_PREGS = 128;
  localparam int NUM_AREGS = 32;
  localparam int ROB_DEPTH = 16;
  localparam int FREE_MAX  = NUM_PREGS - NUM_AREGS;

  typedef logic [6:0] preg_t;
  typedef logic [3:0] rob_tag_t;
  typedef logic [6:0] free_ptr_t;

  // Pointers are exactly log2(NUM_PREGS) bits, so wrap is the natural overflow.
  function automatic free_ptr_t ptr_inc(input free_ptr_t p);
    return p + free_ptr_t'(1);
  endfunction

endpackage

// File: rtl/phys_free_list_ckpt.sv
// Per-ROB-tag snapshot of the free-list head pointer: one write port driven at
// branch dispatch, one asynchronous read port used on mispredict recovery.
module free_list_ckpt
  import phys_free_list_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      we_i,
  input  rob_tag_t  waddr_i,
  input  free_ptr_t wdata_i,
  input  rob_tag_t  raddr_i,
  output free_ptr_t rdata_o
);

  free_ptr_t slot_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else if (we_i) begin
      slot_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = slot_q[raddr_i];

endmodule

// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free tags between rename and
// the ROB, with one-cycle head restore on mispredict.
// Optional sticky err output is built when FREE_LIST_ERR_EN is defined.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int NUM_PREGS = phys_free_list_pkg::NUM_PREGS,
  parameter int NUM_AREGS = phys_free_list_pkg::NUM_AREGS,
  parameter int ROB_DEPTH = phys_free_list_pkg::ROB_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alloc_req,
  output logic [6:0] pd_new,
  output logic       empty,
  output logic [7:0] free_count,
  input  logic       valid_retired,
  input  logic [6:0] preg_old,
  input  logic       ckpt_en,
  input  logic [3:0] ckpt_tag,
  input  logic       mispredict,
`ifdef FREE_LIST_ERR_EN
  input  logic [3:0] mispredict_tag,
  output logic       err
`else
  input  logic [3:0] mispredict_tag
`endif
);

  localparam int FREE_INIT = NUM_PREGS - NUM_AREGS;

  preg_t     storage_q [NUM_PREGS];
  free_ptr_t rptr_q, rptr_d;
  free_ptr_t wptr_q, wptr_d;
  free_ptr_t ckpt_rdata;
  free_ptr_t rptr_alloc;
  logic      alloc_fire;
  logic      ckpt_we;

  assign empty      = (rptr_q == wptr_q);
  assign pd_new     = storage_q[rptr_q];
  assign free_count = {1'b0, wptr_q - rptr_q};

  // Recovery wins over any same-cycle allocation or checkpoint write.
  assign alloc_fire = alloc_req && !empty && !mispredict;
  assign rptr_alloc = alloc_fire ? ptr_inc(rptr_q) : rptr_q;
  assign ckpt_we    = ckpt_en && !mispredict;

  always_comb begin
    rptr_d = rptr_alloc;
    wptr_d = wptr_q;
    if (mispredict) begin
      rptr_d = ckpt_rdata;
    end
    if (valid_retired) begin
      wptr_d = ptr_inc(wptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rptr_q <= '0;
      wptr_q <= free_ptr_t'(FREE_INIT);
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  // Slots past the initial free set are only meaningful once reclaimed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        storage_q[i] <= (i < FREE_INIT) ? preg_t'(NUM_AREGS + i) : '0;
      end
    end else if (valid_retired) begin
      storage_q[wptr_q] <= preg_old;
    end
  end

  // The snapshot holds the head after this cycle's allocation, so the
  // branch's own destination stays allocated across recovery.
  free_list_ckpt #(
    .DEPTH (ROB_DEPTH)
  ) u_ckpt (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ckpt_we),
    .waddr_i (ckpt_tag),
    .wdata_i (rptr_alloc),
    .raddr_i (mispredict_tag),
    .rdata_o (ckpt_rdata)
  );

`ifdef FREE_LIST_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (alloc_req && empty) begin
      err_d = 1'b1;
    end
    if (valid_retired && (free_count == 8'(FREE_INIT))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: vector table for alloc/checkpoint/recovery,
// then hand-written drain, empty, wrap and mid-run reset sequences.
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [6:0] pd_new;
  logic       empty;
  logic [7:0] free_count;
  logic       valid_retired;
  logic [6:0] preg_old;
  logic       ckpt_en;
  logic [3:0] ckpt_tag;
  logic       mispredict;
  logic [3:0] mispredict_tag;
`ifdef FREE_LIST_ERR_EN
  logic       err;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  phys_free_list dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .pd_new         (pd_new),
    .empty          (empty),
    .free_count     (free_count),
    .valid_retired  (valid_retired),
    .preg_old       (preg_old),
    .ckpt_en        (ckpt_en),
    .ckpt_tag       (ckpt_tag),
    .mispredict     (mispredict),
`ifdef FREE_LIST_ERR_EN
    .mispredict_tag (mispredict_tag),
    .err            (err)
`else
    .mispredict_tag (mispredict_tag)
`endif
  );

  typedef struct {
    logic       alloc;
    logic       ret;
    logic [6:0] old;
    logic       cen;
    logic [3:0] ctag;
    logic       mis;
    logic [3:0] mtag;
    logic [6:0] e_pd;
    logic       e_empty;
    logic [7:0] e_fc;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] exp_q[$];

  task automatic add(input logic a, input logic r, input logic [6:0] o,
                     input logic ce, input logic [3:0] ct,
                     input logic m, input logic [3:0] mt,
                     input logic [6:0] pd, input logic em, input logic [7:0] fc);
    vec_t v;
    v = '{alloc: a, ret: r, old: o, cen: ce, ctag: ct, mis: m, mtag: mt,
          e_pd: pd, e_empty: em, e_fc: fc};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic idle_inputs();
    alloc_req = 0; valid_retired = 0; preg_old = 0;
    ckpt_en = 0; ckpt_tag = 0; mispredict = 0; mispredict_tag = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [6:0] tag;

    idle_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
    #1;
    chk("reset_pd_new", 32'(pd_new), 32);
    chk("reset_empty", 32'(empty), 0);
    chk("reset_free_count", 32'(free_count), 96);
`ifdef FREE_LIST_ERR_EN
    chk("reset_err", 32'(err), 0);
`endif

    //   alloc ret old cen ctag mis mtag  pd  empty fc
    add(0, 0, 0,  0, 0, 0, 0,   32, 0, 96);
    add(1, 0, 0,  0, 0, 0, 0,   32, 0, 96);
    add(1, 0, 0,  0, 0, 0, 0,   33, 0, 95);
    add(1, 0, 0,  0, 0, 0, 0,   34, 0, 94);
    add(1, 0, 0,  0, 0, 0, 0,   35, 0, 93);
    add(1, 0, 0,  0, 0, 0, 0,   36, 0, 92);
    add(1, 0, 0,  0, 0, 0, 0,   37, 0, 91);
    add(1, 0, 0,  0, 0, 0, 0,   38, 0, 90);
    add(1, 0, 0,  0, 0, 0, 0,   39, 0, 89);
    add(1, 0, 0,  1, 3, 0, 0,   40, 0, 88);  // branch tag 3 takes 40
    add(1, 0, 0,  0, 0, 0, 0,   41, 0, 87);
    add(1, 0, 0,  0, 0, 0, 0,   42, 0, 86);
    add(1, 0, 0,  0, 0, 0, 0,   43, 0, 85);
    add(0, 0, 0,  0, 0, 1, 3,   44, 0, 84);  // recover to tag 3
    add(0, 0, 0,  0, 0, 0, 0,   41, 0, 87);
    add(1, 0, 0,  0, 0, 0, 0,   41, 0, 87);
    add(1, 0, 0,  1, 5, 0, 0,   42, 0, 86);
    add(1, 0, 0,  0, 0, 0, 0,   43, 0, 85);
    add(1, 1, 9,  1, 3, 1, 5,   44, 0, 84);  // recover + reclaim 9; alloc/ckpt ignored
    add(0, 0, 0,  0, 0, 0, 0,   43, 0, 86);
    add(0, 0, 0,  0, 0, 1, 3,   43, 0, 86);  // tag 3 slot must still hold 9
    add(0, 0, 0,  0, 0, 0, 0,   41, 0, 88);

    for (int i = 0; i < vecs.size(); i++) begin
      alloc_req      = vecs[i].alloc;
      valid_retired  = vecs[i].ret;
      preg_old       = vecs[i].old;
      ckpt_en        = vecs[i].cen;
      ckpt_tag       = vecs[i].ctag;
      mispredict     = vecs[i].mis;
      mispredict_tag = vecs[i].mtag;
      #1;
      chk($sformatf("vec%0d_pd_new", i), 32'(pd_new), 32'(vecs[i].e_pd));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_free_count", i), 32'(free_count), 32'(vecs[i].e_fc));
      step();
      idle_inputs();
    end

    // Reclaim 5 then 7 and drain everything in FIFO order.
    for (int t = 41; t < 128; t++) exp_q.push_back(7'(t));
    exp_q.push_back(7'd9);
    exp_q.push_back(7'd5);
    exp_q.push_back(7'd7);
    valid_retired = 1; preg_old = 7'd5;
    step();
    preg_old = 7'd7;
    step();
    idle_inputs();
    #1;
    chk("after_reclaim_free_count", 32'(free_count), 90);

    n = 0;
    while (!empty && n < 200) begin
      tag = exp_q.pop_front();
      chk($sformatf("drain%0d_pd_new", n), 32'(pd_new), 32'(tag));
      alloc_req = 1;
      step();
      n++;
    end
    alloc_req = 0;
    chk("drain_count", 32'(n), 90);
    chk("drained_empty", 32'(empty), 1);
    chk("drained_free_count", 32'(free_count), 0);
`ifdef FREE_LIST_ERR_EN
    chk("drained_err", 32'(err), 0);
`endif

    // Alloc while empty must be ignored.
    alloc_req = 1;
    step();
    alloc_req = 0;
    #1;
    chk("empty_alloc_empty", 32'(empty), 1);
    chk("empty_alloc_free_count", 32'(free_count), 0);
`ifdef FREE_LIST_ERR_EN
    chk("empty_alloc_err", 32'(err), 1);
`endif

    // Alloc + reclaim while empty: reclaim lands, alloc rejected.
    alloc_req = 1; valid_retired = 1; preg_old = 7'd60;
    #1;
    chk("empty_pair_empty_same_cycle", 32'(empty), 1);
    step();
    idle_inputs();
    #1;
    chk("empty_pair_empty", 32'(empty), 0);
    chk("empty_pair_free_count", 32'(free_count), 1);
    chk("empty_pair_pd_new", 32'(pd_new), 60);

    // 200 alloc/reclaim pairs carry both pointers around the wrap.
    exp_q.delete();
    exp_q.push_back(7'd60);
    for (int i = 0; i < 200; i++) begin
      tag = 7'((i * 37 + 11) & 127);
      chk($sformatf("wrap%0d_pd_new", i), 32'(pd_new), 32'(exp_q.pop_front()));
      chk($sformatf("wrap%0d_free_count", i), 32'(free_count), 1);
      exp_q.push_back(tag);
      alloc_req = 1; valid_retired = 1; preg_old = tag;
      step();
    end
    idle_inputs();
    #1;
    chk("wrap_end_free_count", 32'(free_count), 1);
    chk("wrap_end_pd_new", 32'(pd_new), 32'(exp_q[0]));

    // Reset mid-operation overrides active inputs.
    alloc_req = 1; valid_retired = 1; preg_old = 7'd3; mispredict = 1;
    reset = 0;
    step();
    reset = 1;
    idle_inputs();
    #1;
    chk("rereset_pd_new", 32'(pd_new), 32);
    chk("rereset_empty", 32'(empty), 0);
    chk("rereset_free_count", 32'(free_count), 96);
`ifdef FREE_LIST_ERR_EN
    chk("rereset_err", 32'(err), 0);
`endif
    alloc_req = 1;
    step();
    alloc_req = 0;
    #1;
    chk("rereset_alloc_pd_new", 32'(pd_new), 33);
    chk("rereset_alloc_free_count", 32'(free_count), 95);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
